hazard_forward_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the MIPS core: tracks in-flight register writers

---
 rtl/hazard_forward_unit.sv | 169 ++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: decode-side hazard control for the MIPS pipeline.
// Tracks post-decode register writers in a tag shift register, picks operand
// forwarding sources, stalls decode on dependences that cannot be forwarded
// yet, and squashes decode slots after a taken branch.

// Per-source dependence check against the in-flight writer tags.
module hfu_src_match #(
    parameter int RA_W       = 5,
    parameter int STAGES     = 3,
    parameter int ALU_AVAIL  = 2,
    parameter int LOAD_AVAIL = 3,
    parameter bit FWD_EN     = 1'b1,
    parameter int SEL_W      = 2
) (
    input  logic [STAGES:1]           tag_vld,
    input  logic [STAGES:1][RA_W-1:0] tag_num,
    input  logic [STAGES:1]           tag_ld,
    input  logic [RA_W-1:0]           src,
    input  logic                      used,
    output logic                      hazard,
    output logic [SEL_W-1:0]          sel
);
    logic             hit;
    logic             hit_ld;
    logic             ready;
    logic [SEL_W-1:0] hit_k;

    // Oldest-to-youngest scan so the youngest matching writer is the one kept.
    always_comb begin
        hit    = 1'b0;
        hit_ld = 1'b0;
        hit_k  = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (tag_vld[k] && (tag_num[k] == src)) begin
                hit    = 1'b1;
                hit_ld = tag_ld[k];
                hit_k  = SEL_W'(k);
            end
        end
        // r0 is hardwired zero and unread sources carry no dependence
        if (!used || (src == '0))
            hit = 1'b0;
        ready  = hit_ld ? (hit_k >= SEL_W'(LOAD_AVAIL)) : (hit_k >= SEL_W'(ALU_AVAIL));
        hazard = hit && (!FWD_EN || !ready);
        sel    = (hit && FWD_EN && ready) ? hit_k : '0;
    end
endmodule

module hazard_forward_unit #(
    parameter int RA_W        = 5,
    parameter int STAGES      = 3,
    parameter int ALU_AVAIL   = 2,
    parameter int LOAD_AVAIL  = 3,
    parameter int FLUSH_SLOTS = 2,
    parameter bit FWD_EN      = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [RA_W-1:0]              id_rs,
    input  logic                         id_rs_used,
    input  logic [RA_W-1:0]              id_rt,
    input  logic                         id_rt_used,
    input  logic                         id_wr_en,
    input  logic [RA_W-1:0]              id_wr_num,
    input  logic                         id_is_load,
    input  logic                         branch_taken,
    output logic                         stall,
    output logic                         flush_d,
    output logic [$clog2(STAGES+1)-1:0]  fwd_rs_sel,
    output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);
    localparam int SEL_W = $clog2(STAGES+1);
    localparam int CD_W  = $clog2(FLUSH_SLOTS+1);

    // tag pipe: index k is the writer sitting k stages past decode
    logic [STAGES:1]           vld_pipe;
    logic [STAGES:1][RA_W-1:0] num_pipe;
    logic [STAGES:1]           ld_pipe;
    logic [CD_W-1:0]           flush_cd;

    // lane 0 = rs, lane 1 = rt
    logic [1:0][RA_W-1:0]  src_num;
    logic [1:0]            src_used;
    logic [1:0]            src_haz;
    logic [1:0][SEL_W-1:0] src_sel;
    logic                  any_haz;
    logic                  tag_in;

    assign src_num  = {id_rt, id_rs};
    assign src_used = {id_rt_used, id_rs_used};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_src
            hfu_src_match #(
                .RA_W       (RA_W),
                .STAGES     (STAGES),
                .ALU_AVAIL  (ALU_AVAIL),
                .LOAD_AVAIL (LOAD_AVAIL),
                .FWD_EN     (FWD_EN),
                .SEL_W      (SEL_W)
            ) u_match (
                .tag_vld (vld_pipe),
                .tag_num (num_pipe),
                .tag_ld  (ld_pipe),
                .src     (src_num[g]),
                .used    (src_used[g]),
                .hazard  (src_haz[g]),
                .sel     (src_sel[g])
            );
        end
    endgenerate

    // Hazard and select decode; sels deliberately ignore flush so branch_taken
    // has no combinational path into the forwarding muxes.
    always_comb begin
        any_haz    = |src_haz;
        flush_d    = branch_taken || (flush_cd != '0);
        stall      = id_valid && !flush_d && any_haz;
        fwd_rs_sel = (id_valid && !any_haz) ? src_sel[0] : '0;
        fwd_rt_sel = (id_valid && !any_haz) ? src_sel[1] : '0;
        tag_in     = id_valid && id_wr_en && (id_wr_num != '0) && !stall && !flush_d;
    end

    // Advance the writer tags; stalls and flushes inject an invalid bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            num_pipe <= '0;
            ld_pipe  <= '0;
        end else begin
            vld_pipe[1] <= tag_in;
            num_pipe[1] <= id_wr_num;
            ld_pipe[1]  <= id_is_load;
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                num_pipe[k] <= num_pipe[k-1];
                ld_pipe[k]  <= ld_pipe[k-1];
            end
        end
    end

    // Remaining squash slots after a taken branch; a new branch reloads it.
    always_ff @(posedge clk) begin
        if (rst)
            flush_cd <= '0;
        else if (branch_taken)
            flush_cd <= CD_W'(FLUSH_SLOTS - 1);
        else if (flush_cd != '0)
            flush_cd <= flush_cd - 1'b1;
    end

    // Saturating stall/flush cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_d && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a forwarding instance driven from a
// vector table plus hand sequences, and a non-forwarding instance with narrow
// counters for the stall-only and saturation cases.
module tb_hazard_forward_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, branch_taken;
    logic [4:0] id_rs, id_rt, id_wr_num;

    logic        stall, flush_d;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt, flush_cnt;

    logic        stall_nf, flush_nf;
    logic [1:0]  rs_nf, rt_nf;
    logic [1:0]  scnt_nf, fcnt_nf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_num(id_wr_num), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .stall(stall), .flush_d(flush_d),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_forward_unit #(.FWD_EN(1'b0), .CNT_W(2)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_wr_num(id_wr_num), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .stall(stall_nf), .flush_d(flush_nf),
        .fwd_rs_sel(rs_nf), .fwd_rt_sel(rt_nf),
        .stall_cnt(scnt_nf), .flush_cnt(fcnt_nf)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic       we;
        logic [4:0] wn;
        logic       ld;
        logic       br;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic v, logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu,
                                logic we, logic [4:0] wn, logic ld, logic br,
                                logic st, logic fl, logic [1:0] ers, logic [1:0] ert);
        vec_t r;
        r.v = v; r.rs = rs; r.rsu = rsu; r.rt = rt; r.rtu = rtu;
        r.we = we; r.wn = wn; r.ld = ld; r.br = br;
        r.e_stall = st; r.e_flush = fl; r.e_rs = ers; r.e_rt = ert;
        return r;
    endfunction

    task automatic drive(logic v, logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu,
                         logic we, logic [4:0] wn, logic ld, logic br);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wr_en = we; id_wr_num = wn; id_is_load = ld; branch_taken = br;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_stalls;
        int exp_flushes;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          v rs  u rt  u we wn ld br   st fl rs rt
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // idle after reset
        tbl[1]  = mk(1, 1, 1, 2, 1, 1, 3, 0, 0,  0, 0, 0, 0); // ADD r3
        tbl[2]  = mk(1, 3, 1, 1, 1, 1, 4, 0, 0,  1, 0, 0, 0); // r3 at k1: not ready
        tbl[3]  = mk(1, 3, 1, 1, 1, 1, 4, 0, 0,  0, 0, 2, 0); // r3 at k2
        tbl[4]  = mk(1, 3, 1, 4, 1, 0, 0, 0, 0,  1, 0, 0, 0); // rt r4 at k1 stalls
        tbl[5]  = mk(1, 3, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, 2); // r3 retired, r4 at k2
        tbl[6]  = mk(1, 1, 1, 0, 0, 1, 5, 1, 0,  0, 0, 0, 0); // LW r5
        tbl[7]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0); // load at k1
        tbl[8]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0); // load at k2
        tbl[9]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0); // load at k3
        tbl[10] = mk(1, 0, 1, 0, 1, 1, 7, 0, 0,  0, 0, 0, 0); // r0 never matches
        tbl[11] = mk(1, 0, 1, 0, 1, 1, 7, 0, 0,  0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 0); // three r7 writers
        tbl[13] = mk(1, 7, 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0); // youngest r7 at k1 unready
        tbl[14] = mk(1, 7, 1, 0, 1, 0, 0, 0, 0,  0, 0, 2, 0); // k2 wins over k3
        tbl[15] = mk(1, 1, 1, 7, 0, 0, 0, 0, 0,  0, 0, 0, 0); // unused rt ignores r7 at k3
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 6, 1, 0,  0, 0, 0, 0); // LW r6
        tbl[17] = mk(0, 6, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0); // invalid decode: no stall
        tbl[18] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0); // load at k2
        tbl[19] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0);
        tbl[20] = mk(1, 0, 0, 0, 0, 1, 8, 0, 0,  0, 0, 0, 0); // ADD r8
        tbl[21] = mk(1, 8, 1,10, 1, 1,10, 0, 1,  0, 1, 0, 0); // branch beats stall
        tbl[22] = mk(1, 8, 1,10, 1, 1,10, 0, 0,  0, 1, 2, 0); // second slot, r10 never entered
        tbl[23] = mk(1, 8, 1,10, 1, 1,10, 0, 0,  0, 0, 3, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0); // branch
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0); // reload mid-window
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        do_reset();
        #2;
        chk("reset stall_cnt", stall_cnt, 0);
        chk("reset flush_cnt", flush_cnt, 0);

        exp_stalls  = 0;
        exp_flushes = 0;
        for (int i = 0; i < 28; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
                  tbl[i].we, tbl[i].wn, tbl[i].ld, tbl[i].br);
            #2;
            chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("v%0d flush_d", i), {31'd0, flush_d}, {31'd0, tbl[i].e_flush});
            chk($sformatf("v%0d fwd_rs_sel", i), {30'd0, fwd_rs_sel}, {30'd0, tbl[i].e_rs});
            chk($sformatf("v%0d fwd_rt_sel", i), {30'd0, fwd_rt_sel}, {30'd0, tbl[i].e_rt});
            exp_stalls  += int'(tbl[i].e_stall);
            exp_flushes += int'(tbl[i].e_flush);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("table stall_cnt", stall_cnt, exp_stalls);
        chk("table flush_cnt", flush_cnt, exp_flushes);

        // No forwarding: reader of r3 waits until the writer retires past k3.
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        #2;
        chk("nf writer stall", {31'd0, stall_nf}, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1, 3, 1, 1, 1, 0, 0, 0, 0);
            #2;
            chk($sformatf("nf c%0d stall", c), {31'd0, stall_nf}, 1);
            chk($sformatf("nf c%0d rs_sel", c), {30'd0, rs_nf}, 0);
            chk($sformatf("nf c%0d rt_sel", c), {30'd0, rt_nf}, 0);
        end
        @(negedge clk);
        #2;
        chk("nf release stall", {31'd0, stall_nf}, 0);
        chk("nf release rs_sel", {30'd0, rs_nf}, 0);
        chk("nf stall_cnt 3", {30'd0, scnt_nf}, 3);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
        #2;
        chk("nf rt stall", {31'd0, stall_nf}, 1);
        @(negedge clk);
        #2;
        chk("nf stall_cnt saturates", {30'd0, scnt_nf}, 3);

        // Reset with a full tag pipe while a stall and a flush are pending.
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 11, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 12, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 13, 0, 0);
        @(negedge clk);
        drive(1, 13, 1, 11, 1, 0, 0, 0, 0);
        #2;
        chk("full pipe stall", {31'd0, stall}, 1);
        @(negedge clk);
        drive(1, 13, 1, 11, 1, 0, 0, 0, 1);
        #2;
        chk("branch flush_d", {31'd0, flush_d}, 1);
        chk("branch masks stall", {31'd0, stall}, 0);
        chk("pre-reset stall_cnt", stall_cnt, 1);
        @(negedge clk);
        rst = 1'b1;
        branch_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post-reset stall", {31'd0, stall}, 0);
        chk("post-reset flush_d", {31'd0, flush_d}, 0);
        chk("post-reset stall_cnt", stall_cnt, 0);
        chk("post-reset flush_cnt", flush_cnt, 0);
        chk("post-reset fwd_rs_sel", {30'd0, fwd_rs_sel}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
